mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of BUSY cycles without mem_ack before the grant is aborted (range 2..255).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch read request, held as a level until if_done.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_rdata  output  32  fetched instruction, valid while if_done=1.
REQ-007 SHALL have port if_done  output  1  one-cycle completion pulse for fetch.
REQ-008 SHALL have port if_stall  output  1  freezes PC and IF/ID.
REQ-009 SHALL have port dm_req  input  1  data-access request from EX/MEM, held as a level until dm_done.
REQ-010 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have ports dm_addr  input  32 and dm_wdata  input  32, the data address and store data.
REQ-012 SHALL have ports dm_rdata  output  32 (load data, valid while dm_done=1) and dm_done  output  1 (one-cycle pulse).
REQ-013 SHALL have port dm_stall  output  1  freezes all stages up to and including EX/MEM.
REQ-014 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32 and mem_wdata  output  32, the single-port memory request side.
REQ-015 SHALL have ports mem_rdata  input  32 and mem_ack  input  1, memory response; mem_ack is a one-cycle pulse with variable latency of 0 or more cycles after mem_req is first high.
REQ-016 SHALL have port timeout_err  output  1  sticky flag, set when any grant times out.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM and RESP.
REQ-018 In IDLE, with dm_req=1, SHALL go to BUSY_DM: data is the older instruction, so DM has fixed priority.
REQ-019 In IDLE, with dm_req=0 and if_req=1, SHALL go to BUSY_IF.
REQ-020 In IDLE with no request, SHALL stay in IDLE.
REQ-021 On entering BUSY_*, SHALL latch the winner's address with bits [1:0] forced to 0, plus we and wdata (we=0 for IF).
REQ-022 SHALL drive mem_req=1 and the latched fields from registers for every BUSY_* cycle, and mem_req=0 in IDLE and RESP.
REQ-023 In BUSY_*, when mem_ack=1, SHALL capture mem_rdata into the granted requester's rdata register and go to RESP.
REQ-024 In RESP, SHALL pulse the granted requester's done for exactly one cycle, then go to IDLE.
REQ-025 Minimum latency SHALL be: req sampled at t, mem_req at t+1, ack at t+1, done at t+2, next grant possible from t+3.
REQ-026 For a store, SHALL pulse dm_done; dm_rdata is don't-care.
REQ-027 SHALL set if_stall = if_req AND NOT if_done, and dm_stall = dm_req AND NOT dm_done (combinational).
REQ-028 SHALL increment an 8-bit counter each BUSY_* cycle without mem_ack, clearing it on entry to BUSY_*.
REQ-029 When the counter reaches TIMEOUT, SHALL set timeout_err, drop mem_req, load rdata with 0 and go to RESP, so done still pulses and the pipeline cannot hang.
REQ-030 SHALL ignore mem_ack in IDLE and RESP (late or spurious acks).
REQ-031 SHALL leave a requester whose req deasserts before done ungranted in IDLE; an in-flight grant SHALL complete regardless.
REQ-032 SHALL never grant a request in the same cycle its done pulses: the request is re-sampled in IDLE.

Reset
REQ-033 When Reset=1 at an edge, SHALL go to IDLE and clear the counter.
REQ-034 When Reset=1 at an edge, SHALL set mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, dm_done=0, if_rdata=0, dm_rdata=0 and timeout_err=0.
REQ-035 Reset mid-BUSY SHALL abort without a done pulse; an ack arriving after reset SHALL be ignored.

Structure
REQ-036 Package mips_mem_pkg SHALL hold the FSM state enum, the default TIMEOUT constant and the 32-bit word type.
REQ-037 Sub-module arb_timeout_counter SHALL provide the clear/enable/terminal-count counter; the FSM and datapath registers stay in mem_port_arbiter.

Verification
REQ-038 IF-only: if_req=1, if_addr=0x0000_0042, ack one cycle after mem_req with rdata=0x2001_0005 -> mem_addr=0x0000_0040, mem_we=0, if_done pulse with if_rdata=0x2001_0005, if_stall low in the done cycle.
REQ-039 Simultaneous: if_req and dm_req (load, 0x100) high at t -> DM granted first, dm_done, then IF granted starting from IDLE; if_stall high throughout.
REQ-040 Store: dm_we=1, dm_addr=0x0000_0200, dm_wdata=0xDEAD_BEEF -> mem_we=1, mem_wdata=0xDEAD_BEEF, single dm_done pulse.
REQ-041 Timeout: TIMEOUT=15, mem_ack never asserted -> mem_req drops after 15 BUSY cycles, timeout_err=1 and stays set, dm_done pulses with dm_rdata=0.
REQ-042 Reset at the 3rd BUSY cycle followed by a late mem_ack -> IDLE, no done pulse, all outputs 0, ack ignored.
REQ-043 Back-to-back fetches with 0-cycle-latency ack -> one completion every 3 cycles, no lost or duplicated done pulses.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the single-port memory arbiter.
//   word_t          : 32-bit data/address word
//   arb_state_e     : arbiter FSM states
//   DEFAULT_TIMEOUT : default abort limit in BUSY cycles without mem_ack
//   word_align()    : clears the byte-offset bits of an address
package mips_mem_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned DEFAULT_TIMEOUT = 15;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_DM,
      RESP
   } arb_state_e;

   function automatic word_t word_align(input word_t addr);
      return addr & ~word_t'(3);
   endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog counter for an outstanding memory grant.
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset, clears the count
//   clear  : synchronous clear (wins over enable)
//   enable : count one more cycle without a memory acknowledge
//   last   : current count is LIMIT-1, so an enabled cycle now reaches LIMIT
module arb_timeout_counter #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic last
);

   logic [7:0] count_q;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count_q <= 8'd0;
      end else if (enable) begin
         count_q <= count_q + 8'd1;
      end
   end

   // Flag the final permitted cycle so the abort lands exactly when the count hits LIMIT.
   assign last = (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch (IF) and data
// memory (DM) requesters of a pipelined core. DM has fixed priority.
//   clock, Reset                   : clock and synchronous active-high reset
//   if_req/if_addr                 : fetch request (level, held until if_done)
//   if_rdata/if_done/if_stall      : fetch data, completion pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata  : data request (level, held until dm_done)
//   dm_rdata/dm_done/dm_stall      : load data, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   mem_rdata/mem_ack              : memory response, ack is a one-cycle pulse
//   timeout_err                    : sticky, set when a grant is aborted
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic  clock,
   input  logic  Reset,

   input  logic  if_req,
   input  word_t if_addr,
   output word_t if_rdata,
   output logic  if_done,
   output logic  if_stall,

   input  logic  dm_req,
   input  logic  dm_we,
   input  word_t dm_addr,
   input  word_t dm_wdata,
   output word_t dm_rdata,
   output logic  dm_done,
   output logic  dm_stall,

   output logic  mem_req,
   output logic  mem_we,
   output word_t mem_addr,
   output word_t mem_wdata,
   input  word_t mem_rdata,
   input  logic  mem_ack,

   output logic  timeout_err
);

   arb_state_e state_q, state_d;
   logic       grant_dm_q, grant_dm_d;
   logic       mem_we_q, mem_we_d;
   word_t      mem_addr_q, mem_addr_d;
   word_t      mem_wdata_q, mem_wdata_d;
   word_t      if_rdata_q, if_rdata_d;
   word_t      dm_rdata_q, dm_rdata_d;
   logic       timeout_err_q, timeout_err_d;

   logic       busy;
   logic       cnt_clear;
   logic       cnt_enable;
   logic       cnt_last;

   assign busy = (state_q == BUSY_IF) || (state_q == BUSY_DM);

   // Outside BUSY the counter is held at zero, so every grant starts from a clean count.
   assign cnt_clear  = !busy;
   assign cnt_enable = busy && !mem_ack;

   arb_timeout_counter #(
      .LIMIT(TIMEOUT)
   ) u_timeout_counter (
      .clock  (clock),
      .reset  (Reset),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .last   (cnt_last)
   );

   always_comb begin
      state_d       = state_q;
      grant_dm_d    = grant_dm_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_rdata_d    = if_rdata_q;
      dm_rdata_d    = dm_rdata_q;
      timeout_err_d = timeout_err_q;

      unique case (state_q)
         IDLE: begin
            // Data access belongs to the older instruction, so it wins a tie.
            if (dm_req) begin
               state_d     = BUSY_DM;
               grant_dm_d  = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = word_align(dm_addr);
               mem_wdata_d = dm_wdata;
            end else if (if_req) begin
               state_d     = BUSY_IF;
               grant_dm_d  = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = word_align(if_addr);
               mem_wdata_d = '0;
            end
         end

         BUSY_IF, BUSY_DM: begin
            // An ack in the final permitted cycle still completes normally.
            if (mem_ack) begin
               state_d = RESP;
               if (state_q == BUSY_DM) begin
                  dm_rdata_d = mem_rdata;
               end else begin
                  if_rdata_d = mem_rdata;
               end
            end else if (cnt_last) begin
               // Abort with zero data so the stalled pipeline still sees a done pulse.
               state_d       = RESP;
               timeout_err_d = 1'b1;
               if (state_q == BUSY_DM) begin
                  dm_rdata_d = '0;
               end else begin
                  if_rdata_d = '0;
               end
            end
         end

         RESP: begin
            // Requests are re-sampled only in IDLE, never in the done cycle.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q       <= IDLE;
         grant_dm_q    <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         dm_rdata_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_dm_q    <= grant_dm_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_rdata_q    <= if_rdata_d;
         dm_rdata_q    <= dm_rdata_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_req     = busy;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

   assign if_done     = (state_q == RESP) && !grant_dm_q;
   assign dm_done     = (state_q == RESP) && grant_dm_q;
   assign if_rdata    = if_rdata_q;
   assign dm_rdata    = dm_rdata_q;

   assign if_stall    = if_req && !if_done;
   assign dm_stall    = dm_req && !dm_done;

   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clock;
   logic        Reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_done;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        timeout_err;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter dut (
      .clock       (clock),
      .Reset       (Reset),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_done     (if_done),
      .if_stall    (if_stall),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .dm_done     (dm_done),
      .dm_stall    (dm_stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .timeout_err (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      Reset = 1'b1;
      if_req = 1'b0;
      dm_req = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      Reset = 1'b0;
   endtask

   // One isolated transaction, starting and ending with the arbiter idle.
   typedef struct {
      logic        dm;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic run_vec(input vec_t v);
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      if (v.dm) begin
         dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      @(negedge clock);
      chk1("vec idle mem_req", mem_req, 1'b0);
      for (int k = 0; k <= v.lat; k++) begin
         @(posedge clock);
         #1;
         mem_ack = (k == v.lat);
         mem_rdata = (k == v.lat) ? v.rdata : 32'h0BAD_0BAD;
         @(negedge clock);
         chk1("vec busy mem_req", mem_req, 1'b1);
         chk1("vec busy done", v.dm ? dm_done : if_done, 1'b0);
         if (k == 0) begin
            chk32("vec mem_addr", mem_addr, v.exp_addr);
            chk1("vec mem_we", mem_we, v.exp_we);
            if (v.exp_we) chk32("vec mem_wdata", mem_wdata, v.wdata);
         end
      end
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      @(negedge clock);
      chk1("vec resp mem_req", mem_req, 1'b0);
      chk1("vec done", v.dm ? dm_done : if_done, 1'b1);
      chk1("vec other done", v.dm ? if_done : dm_done, 1'b0);
      chk1("vec stall in done", v.dm ? dm_stall : if_stall, 1'b0);
      if (!v.exp_we) chk32("vec rdata", v.dm ? dm_rdata : if_rdata, v.exp_rdata);
      @(posedge clock);
      #1;
      if_req = 1'b0;
      dm_req = 1'b0;
      @(negedge clock);
      chk1("vec done cleared", v.dm ? dm_done : if_done, 1'b0);
   endtask

   // Random-phase reference: one transaction at a time, timed by cycle arithmetic.
   bit          m_active;
   bit          m_dm;
   bit          m_we;
   int          m_busy_from, m_ack_at, m_done_at;
   logic [31:0] m_addr, m_wdata, m_rdata;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ndone;
      int last_done;
      int j;
      bit prev_done;
      bit in_window, exp_ifd, exp_dmd, free;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0042, 32'h0, 32'h2001_0005, 1,
                  32'h0000_0040, 1'b0, 32'h2001_0005};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 0,
                  32'h0000_0200, 1'b1, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h1234_5678, 2,
                  32'h0000_0100, 1'b0, 32'h1234_5678};
      vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'hCAFE_F00D, 0,
                  32'hFFFF_FFFC, 1'b0, 32'hCAFE_F00D};
      vecs[4] = '{1'b1, 1'b1, 32'h8000_0001, 32'h0000_0001, 32'h0, 4,
                  32'h8000_0000, 1'b1, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0, 32'hA5A5_A5A5, 14,
                  32'h0000_0004, 1'b0, 32'hA5A5_A5A5};
      vecs[6] = '{1'b0, 1'b0, 32'h1234_5676, 32'h0, 32'h0BAD_C0DE, 3,
                  32'h1234_5674, 1'b0, 32'h0BAD_C0DE};

      Reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
      do_reset();

      // Reset state
      @(negedge clock);
      chk1("rst mem_req", mem_req, 1'b0);
      chk1("rst mem_we", mem_we, 1'b0);
      chk32("rst mem_addr", mem_addr, 32'h0);
      chk32("rst mem_wdata", mem_wdata, 32'h0);
      chk1("rst if_done", if_done, 1'b0);
      chk1("rst dm_done", dm_done, 1'b0);
      chk32("rst if_rdata", if_rdata, 32'h0);
      chk32("rst dm_rdata", dm_rdata, 32'h0);
      chk1("rst timeout_err", timeout_err, 1'b0);

      // Table of isolated transactions (ack on the last permitted cycle is in vecs[5])
      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i]);
         chk1("vec timeout_err", timeout_err, 1'b0);
      end

      // Simultaneous requests: DM first, IF re-arbitrated from IDLE
      @(posedge clock); #1;
      if_req = 1'b1; if_addr = 32'h0000_0300;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100; mem_ack = 1'b0;
      @(negedge clock);
      chk1("sim idle mem_req", mem_req, 1'b0);
      chk1("sim idle if_stall", if_stall, 1'b1);
      chk1("sim idle dm_stall", dm_stall, 1'b1);
      @(posedge clock); #1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      @(negedge clock);
      chk1("sim dm mem_req", mem_req, 1'b1);
      chk32("sim dm mem_addr", mem_addr, 32'h0000_0100);
      chk1("sim dm if_stall", if_stall, 1'b1);
      @(posedge clock); #1; mem_ack = 1'b0;
      @(negedge clock);
      chk1("sim dm_done", dm_done, 1'b1);
      chk32("sim dm_rdata", dm_rdata, 32'h1111_2222);
      chk1("sim if_done early", if_done, 1'b0);
      chk1("sim resp if_stall", if_stall, 1'b1);
      chk1("sim resp dm_stall", dm_stall, 1'b0);
      @(posedge clock); #1; dm_req = 1'b0;
      @(negedge clock);
      chk1("sim gap mem_req", mem_req, 1'b0);
      chk1("sim gap if_stall", if_stall, 1'b1);
      @(posedge clock); #1; mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
      @(negedge clock);
      chk1("sim if mem_req", mem_req, 1'b1);
      chk32("sim if mem_addr", mem_addr, 32'h0000_0300);
      chk1("sim if mem_we", mem_we, 1'b0);
      chk1("sim if if_stall", if_stall, 1'b1);
      @(posedge clock); #1; mem_ack = 1'b0;
      @(negedge clock);
      chk1("sim if_done", if_done, 1'b1);
      chk32("sim if_rdata", if_rdata, 32'h3333_4444);
      chk1("sim if dm_done", dm_done, 1'b0);
      chk1("sim done if_stall", if_stall, 1'b0);
      @(posedge clock); #1; if_req = 1'b0;
      @(negedge clock);
      chk1("sim end if_done", if_done, 1'b0);

      // Timeout: never acknowledge a DM load
      @(posedge clock); #1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0044; mem_ack = 1'b0;
      @(negedge clock);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         @(negedge clock);
         if (mem_req) n++;
         else break;
      end
      chk32("timeout busy cycles", 32'(n), 32'd15);
      chk1("timeout dm_done", dm_done, 1'b1);
      chk32("timeout dm_rdata", dm_rdata, 32'h0);
      chk1("timeout err set", timeout_err, 1'b1);
      @(posedge clock); #1; dm_req = 1'b0;
      @(negedge clock);
      chk1("timeout done once", dm_done, 1'b0);
      run_vec(vecs[0]);
      chk1("timeout err sticky", timeout_err, 1'b1);

      // Reset in the 3rd BUSY cycle, then a late ack
      @(posedge clock); #1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0500; dm_wdata = 32'h0000_0055;
      @(negedge clock);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clock); #1;
         if (i == 3) Reset = 1'b1;
         @(negedge clock);
         chk1("rbusy mem_req", mem_req, 1'b1);
      end
      @(posedge clock); #1;
      Reset = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
      @(negedge clock);
      chk1("rbusy mem_req off", mem_req, 1'b0);
      chk1("rbusy mem_we", mem_we, 1'b0);
      chk32("rbusy mem_addr", mem_addr, 32'h0);
      chk32("rbusy mem_wdata", mem_wdata, 32'h0);
      chk1("rbusy dm_done", dm_done, 1'b0);
      chk1("rbusy if_done", if_done, 1'b0);
      chk32("rbusy if_rdata", if_rdata, 32'h0);
      chk32("rbusy dm_rdata", dm_rdata, 32'h0);
      chk1("rbusy timeout_err", timeout_err, 1'b0);
      @(posedge clock); #1; mem_ack = 1'b0;
      @(negedge clock);
      chk1("rbusy late dm_done", dm_done, 1'b0);
      chk1("rbusy late mem_req", mem_req, 1'b0);
      chk32("rbusy late dm_rdata", dm_rdata, 32'h0);

      // Back-to-back fetches with zero-latency memory: one done every 3 cycles
      ndone = 0; last_done = -1; j = 0; prev_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clock); #1;
         if (c == 0) begin
            if_req = 1'b1; if_addr = 32'h0000_1000;
         end else if (prev_done) begin
            j++;
            if_addr = 32'h0000_1000 + 32'(4 * j);
         end
         mem_ack = mem_req;
         mem_rdata = mem_addr ^ 32'hA5A5_0000;
         @(negedge clock);
         prev_done = if_done;
         if (if_done) begin
            chk32("b2b if_rdata", if_rdata, (32'h0000_1000 + 32'(4 * j)) ^ 32'hA5A5_0000);
            if (last_done >= 0) chk32("b2b spacing", 32'(c - last_done), 32'd3);
            last_done = c;
            ndone++;
         end
      end
      chk32("b2b done count", 32'(ndone), 32'd10);
      @(posedge clock); #1; if_req = 1'b0; mem_ack = 1'b0;

      // Randomised traffic against the transaction-timing model
      do_reset();
      m_active = 1'b0; m_dm = 1'b0; m_we = 1'b0;
      m_busy_from = 0; m_ack_at = 0; m_done_at = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clock); #1;
         // IF requester
         if (if_req && m_active && !m_dm && c == m_done_at + 1) begin
            if ($urandom_range(1, 0) == 1) if_addr = $urandom;
            else if_req = 1'b0;
         end else if (if_req && !(m_active && !m_dm && c <= m_done_at)
                      && $urandom_range(9, 0) == 0) begin
            if_req = 1'b0;
         end else if (!if_req && $urandom_range(2, 0) == 0) begin
            if_req = 1'b1; if_addr = $urandom;
         end
         // DM requester
         if (dm_req && m_active && m_dm && c == m_done_at + 1) begin
            if ($urandom_range(1, 0) == 1) begin
               dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom_range(1, 0));
            end else begin
               dm_req = 1'b0;
            end
         end else if (dm_req && !(m_active && m_dm && c <= m_done_at)
                      && $urandom_range(9, 0) == 0) begin
            dm_req = 1'b0;
         end else if (!dm_req && $urandom_range(3, 0) == 0) begin
            dm_req = 1'b1; dm_addr = $urandom; dm_wdata = $urandom;
            dm_we = 1'($urandom_range(1, 0));
         end
         // Memory: scheduled ack, plus occasional spurious acks outside the access window
         in_window = m_active && c >= m_busy_from && c <= m_ack_at;
         if (m_active && c == m_ack_at) begin
            mem_ack = 1'b1; mem_rdata = m_rdata;
         end else if (!in_window && $urandom_range(7, 0) == 0) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
         end else begin
            mem_ack = 1'b0; mem_rdata = $urandom;
         end
         @(negedge clock);
         exp_ifd = m_active && !m_dm && c == m_done_at;
         exp_dmd = m_active && m_dm && c == m_done_at;
         chk1("rnd mem_req", mem_req, in_window);
         chk1("rnd if_done", if_done, exp_ifd);
         chk1("rnd dm_done", dm_done, exp_dmd);
         chk1("rnd if_stall", if_stall, if_req && !exp_ifd);
         chk1("rnd dm_stall", dm_stall, dm_req && !exp_dmd);
         chk1("rnd timeout_err", timeout_err, 1'b0);
         if (in_window) begin
            chk32("rnd mem_addr", mem_addr, m_addr);
            chk1("rnd mem_we", mem_we, m_we);
            if (m_we) chk32("rnd mem_wdata", mem_wdata, m_wdata);
         end
         if (exp_ifd) chk32("rnd if_rdata", if_rdata, m_rdata);
         if (exp_dmd && !m_we) chk32("rnd dm_rdata", dm_rdata, m_rdata);
         // Arbitration decision at the end of a free cycle
         free = !m_active || c > m_done_at;
         if (free && (dm_req || if_req)) begin
            m_active    = 1'b1;
            m_dm        = dm_req;
            m_addr      = (dm_req ? dm_addr : if_addr) & 32'hFFFF_FFFC;
            m_we        = dm_req ? dm_we : 1'b0;
            m_wdata     = dm_wdata;
            m_rdata     = $urandom;
            m_busy_from = c + 1;
            m_ack_at    = c + 1 + int'($urandom_range(3, 0));
            m_done_at   = m_ack_at + 1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
